// File: rtl/field_decoder_pkg.sv
// Shared types and helpers for the field one-hot decoder.
// Index values are carried at a fixed maximum width so one entry type serves
// every parameterisation; the top slices down to its own SEL_W / OUT_N.
package field_decoder_pkg;

    localparam int SEL_W_MAX  = 8;
    localparam int ONEHOT_MAX = 2 ** SEL_W_MAX;

    // One decoded entry: enable flag plus already-clamped index.
    typedef struct packed {
        logic                 en;
        logic [SEL_W_MAX-1:0] idx;
    } dec_entry_t;

    // Saturate an index to the last legal output position.
    function automatic logic [SEL_W_MAX-1:0] clamp_idx(
        input logic [SEL_W_MAX-1:0] idx,
        input int unsigned          out_n
    );
        if (32'(idx) >= out_n) begin
            return SEL_W_MAX'(out_n - 32'd1);
        end
        return idx;
    endfunction

    // Single set bit at idx, or all zero when en is low.
    function automatic logic [ONEHOT_MAX-1:0] onehot(
        input logic                 en,
        input logic [SEL_W_MAX-1:0] idx
    );
        logic [ONEHOT_MAX-1:0] v;
        v = '0;
        if (en) begin
            v[idx] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/dec_skid_buffer.sv
// Generic two-entry valid/ready skid buffer: a main (output) register plus a
// skid register that catches a word accepted while the sink stalls.
// in_ready_o is registered and depends only on skid occupancy, so there is no
// combinational path from out_ready_i back to the source. No bypass: an
// accepted word is visible on the output the following cycle at the earliest.
module dec_skid_buffer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_data_o
);

    logic [W-1:0] main_q, main_d;
    logic [W-1:0] skid_q, skid_d;
    logic         main_vld_q, main_vld_d;
    logic         skid_vld_q, skid_vld_d;
    logic         rdy_q, rdy_d;
    logic         push;
    logic         pop;

    assign push = in_valid_i && rdy_q;
    assign pop  = main_vld_q && out_ready_i;

    // Next-state: refill main from skid first, otherwise load main or spill to skid.
    always_comb begin
        main_d     = main_q;
        skid_d     = skid_q;
        main_vld_d = main_vld_q;
        skid_vld_d = skid_vld_q;
        if (skid_vld_q) begin
            // Full: no accept possible (rdy_q is low); drain skid into main on pop.
            if (pop) begin
                main_d     = skid_q;
                skid_vld_d = 1'b0;
            end
        end else if (!main_vld_q || pop) begin
            main_vld_d = push;
            if (push) begin
                main_d = in_data_i;
            end
        end else if (push) begin
            skid_vld_d = 1'b1;
            skid_d     = in_data_i;
        end
        rdy_d = !skid_vld_d;
    end

    // State registers; reset drops both held entries and closes the input.
    always_ff @(posedge clk) begin
        if (reset) begin
            main_q     <= '0;
            skid_q     <= '0;
            main_vld_q <= 1'b0;
            skid_vld_q <= 1'b0;
            rdy_q      <= 1'b0;
        end else begin
            main_q     <= main_d;
            skid_q     <= skid_d;
            main_vld_q <= main_vld_d;
            skid_vld_q <= skid_vld_d;
            rdy_q      <= rdy_d;
        end
    end

    assign in_ready_o  = rdy_q;
    assign out_valid_o = main_vld_q;
    assign out_data_o  = main_q;

endmodule

// File: rtl/field_onehot_decoder.sv
// Registered field decoder: pulls a SEL_W-bit index out of read_data, clamps it
// to OUT_N-1, queues it through a 2-entry skid buffer and drives a one-hot
// enable vector L (all zero when the entry's enable is low).
// Optional macro DECODER_SCOREBOARD_EN adds a busy scoreboard: issued targets
// are marked busy until released, and an entry hitting a busy target stalls.
module field_onehot_decoder
    import field_decoder_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int SEL_LSB = 8,
    parameter int SEL_W   = 3,
    parameter int OUT_N   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] read_data,
    input  logic              in_en,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_N-1:0]  L,
    output logic [SEL_W-1:0]  out_idx
`ifdef DECODER_SCOREBOARD_EN
    ,
    input  logic              rel_valid,
    input  logic [SEL_W-1:0]  rel_idx,
    output logic [OUT_N-1:0]  busy
`endif
);

    if (SEL_LSB + SEL_W > DATA_W) begin : g_bad_field
        $error("index field does not fit inside read_data");
    end
    if (OUT_N < 2 || OUT_N > 2 ** SEL_W) begin : g_bad_out_n
        $error("OUT_N must lie in 2 .. 2**SEL_W");
    end
    if (SEL_W > SEL_W_MAX) begin : g_bad_sel_w
        $error("SEL_W exceeds the package index width");
    end

    dec_entry_t            in_entry;
    dec_entry_t            out_entry;
    logic                  held;
    logic                  hazard;
    logic [ONEHOT_MAX-1:0] onehot_full;
    logic                  unused_bits;

    // Clamp happens before the skid so held entries are always legal targets.
    assign in_entry.en  = in_en;
    assign in_entry.idx = clamp_idx(SEL_W_MAX'(read_data[SEL_LSB +: SEL_W]), OUT_N);

    dec_skid_buffer #(
        .W ($bits(dec_entry_t))
    ) u_skid (
        .clk         (clk),
        .reset       (reset),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_entry),
        .out_valid_o (held),
        .out_ready_i (out_ready && !hazard),
        .out_data_o  (out_entry)
    );

    // One-hot after the skid; gated by held so an empty output shows L = 0.
    assign onehot_full = onehot(held && out_entry.en, out_entry.idx);
    assign L           = onehot_full[OUT_N-1:0];
    assign out_idx     = out_entry.idx[SEL_W-1:0];
    assign out_valid   = held && !hazard;

    assign unused_bits = ^{read_data, onehot_full, out_entry.idx};

`ifdef DECODER_SCOREBOARD_EN
    logic [OUT_N-1:0]      busy_q, busy_d;
    logic [OUT_N-1:0]      set_vec;
    logic [OUT_N-1:0]      clr_vec;
    logic [ONEHOT_MAX-1:0] rel_full;
    logic                  unused_rel;

    assign rel_full   = onehot(rel_valid, clamp_idx(SEL_W_MAX'(rel_idx), OUT_N));
    assign clr_vec    = rel_full[OUT_N-1:0];
    assign set_vec    = (out_valid && out_ready) ? L : '0;
    assign hazard     = |(busy_q & L);
    assign unused_rel = ^rel_full;

    // Release then issue, so a same-cycle set on the same bit wins.
    always_comb begin
        busy_d = (busy_q & ~clr_vec) | set_vec;
    end

    // Busy scoreboard register.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;
`else
    assign hazard = 1'b0;
`endif

endmodule

// File: tb/tb_field_onehot_decoder.sv
// Bench for field_onehot_decoder: a default instance (OUT_N=8) and a clamping
// instance (OUT_N=6) share stimulus; a queue-level model predicts both.
module tb_field_onehot_decoder;

`ifdef DECODER_SCOREBOARD_EN
    localparam bit SB = 1'b1;
`else
    localparam bit SB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_en = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] read_data = '0;
    logic        rel_valid = 1'b0;
    logic [2:0]  rel_idx = '0;

    logic        ir0, ov0, ir1, ov1;
    logic [7:0]  l0;
    logic [5:0]  l1;
    logic [2:0]  oi0, oi1;
    logic [7:0]  busy0 = '0;
    logic [5:0]  busy1 = '0;

    always #5 clk = ~clk;

    field_onehot_decoder #(.DATA_W(32), .SEL_LSB(8), .SEL_W(3), .OUT_N(8)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir0),
        .read_data(read_data), .in_en(in_en), .out_valid(ov0),
        .out_ready(out_ready), .L(l0), .out_idx(oi0)
`ifdef DECODER_SCOREBOARD_EN
        , .rel_valid(rel_valid), .rel_idx(rel_idx), .busy(busy0)
`endif
    );

    field_onehot_decoder #(.DATA_W(32), .SEL_LSB(8), .SEL_W(3), .OUT_N(6)) dut6 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir1),
        .read_data(read_data), .in_en(in_en), .out_valid(ov1),
        .out_ready(out_ready), .L(l1), .out_idx(oi1)
`ifdef DECODER_SCOREBOARD_EN
        , .rel_valid(rel_valid), .rel_idx(rel_idx), .busy(busy1)
`endif
    );

    // ---------------- reference model: in-order list of up to two entries
    typedef struct { bit en; int idx; } ment_t;
    ment_t    mq[2][2];
    int       mcnt[2] = '{0, 0};
    bit       mrdy[2] = '{0, 0};
    bit [7:0] mbusy[2] = '{8'h00, 8'h00};
    int       ns[2] = '{8, 6};

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    function automatic int clampm(input int i, input int n);
        return (i >= n) ? n - 1 : i;
    endfunction

    function automatic bit m_ov(input int k);
        if (mcnt[k] == 0) return 1'b0;
        if (SB && mq[k][0].en && mbusy[k][mq[k][0].idx]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int m_l(input int k);
        if (mcnt[k] == 0 || !mq[k][0].en) return 0;
        return 1 << mq[k][0].idx;
    endfunction

    task automatic model_step(input int k);
        bit    pop, acc;
        ment_t e;
        if (reset) begin
            mcnt[k] = 0; mbusy[k] = '0; mrdy[k] = 1'b0;
            return;
        end
        pop = m_ov(k) && out_ready;
        acc = in_valid && mrdy[k];
        if (SB) begin
            if (rel_valid) mbusy[k][clampm(int'(rel_idx), ns[k])] = 1'b0;
            if (pop && mq[k][0].en) mbusy[k][mq[k][0].idx] = 1'b1;
        end
        if (pop) begin
            mq[k][0] = mq[k][1];
            mcnt[k]--;
        end
        if (acc) begin
            e.en  = in_en;
            e.idx = clampm(int'((read_data >> 8) & 32'h7), ns[k]);
            mq[k][mcnt[k]] = e;
            mcnt[k]++;
        end
        mrdy[k] = (mcnt[k] < 2);
    endtask

    task automatic check_inst(input int k, input bit ov, input int lv, input int ix,
                              input bit ir, input int bz);
        string p;
        p = (k == 0) ? "n8" : "n6";
        chk({p, "_out_valid"}, int'(ov), int'(m_ov(k)));
        chk({p, "_L"}, lv, m_l(k));
        chk({p, "_in_ready"}, int'(ir), int'(mrdy[k]));
        if (mcnt[k] > 0) chk({p, "_out_idx"}, ix, mq[k][0].idx);
`ifdef DECODER_SCOREBOARD_EN
        chk({p, "_busy"}, bz, int'(mbusy[k]));
`else
        if (bz != 0) chk({p, "_busy_tie"}, bz, 0);
`endif
    endtask

    // Sample away from the active edge and compare both instances to the model.
    task automatic sample_check();
        @(negedge clk);
        check_inst(0, ov0, int'(l0), int'(oi0), ir0, int'(busy0));
        check_inst(1, ov1, int'(l1), int'(oi1), ir1, int'(busy1));
    endtask

    task automatic advance();
        model_step(0);
        model_step(1);
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input bit en, input int idx, input bit ordy);
        in_valid  = v;
        in_en     = en;
        read_data = ($urandom & ~32'h0000_0700) | (32'(idx & 7) << 8);
        out_ready = ordy;
    endtask

    task automatic do_reset();
        reset = 1'b1; in_valid = 1'b0; rel_valid = 1'b0;
        sample_check();
        advance();
        reset = 1'b0;
        sample_check();
        advance();
    endtask

    typedef struct {
        bit v; bit en; int idx; bit ordy;
        bit eov; int el8; int el6; int ei8; int ei6;
    } vec_t;

    vec_t tbl[12];
    int   got[$];
    int   pend[$];
    bit   saw_stall;

    initial begin
        tbl[0]  = '{1, 1, 0, 1, 0, 'h00, 'h00, 0, 0};
        tbl[1]  = '{1, 1, 1, 1, 1, 'h01, 'h01, 0, 0};
        tbl[2]  = '{1, 1, 2, 1, 1, 'h02, 'h02, 1, 1};
        tbl[3]  = '{1, 1, 3, 1, 1, 'h04, 'h04, 2, 2};
        tbl[4]  = '{1, 1, 4, 1, 1, 'h08, 'h08, 3, 3};
        tbl[5]  = '{1, 1, 5, 1, 1, 'h10, 'h10, 4, 4};
        tbl[6]  = '{1, 1, 6, 1, 1, 'h20, 'h20, 5, 5};
        tbl[7]  = '{1, 1, 7, 1, 1, 'h40, 'h20, 6, 5};
        tbl[8]  = '{1, 0, 3, 1, 1, 'h80, 'h20, 7, 5};
        tbl[9]  = '{1, 1, 7, 1, 1, 'h00, 'h00, 3, 3};
        tbl[10] = '{0, 0, 0, 1, 1, 'h80, 'h20, 7, 5};
        tbl[11] = '{0, 0, 0, 1, 0, 'h00, 'h00, 0, 0};

        // Power-up reset, then the reset-state checks.
        reset = 1'b1;
        advance();
        reset = 1'b0;
        sample_check();
        chk("rst_out_valid", int'(ov0), 0);
        chk("rst_L", int'(l0), 0);
        chk("rst_out_idx", int'(oi0), 0);
        chk("rst_in_ready", int'(ir0), 0);
        advance();

        // Back-to-back sweep, clamp and en=0 rows.
        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].v, tbl[i].en, tbl[i].idx, tbl[i].ordy);
            rel_valid = tbl[i].v;
            rel_idx   = 3'(tbl[i].idx);
            sample_check();
            chk($sformatf("tbl%0d_n8_valid", i), int'(ov0), int'(tbl[i].eov));
            chk($sformatf("tbl%0d_n8_L", i), int'(l0), tbl[i].el8);
            chk($sformatf("tbl%0d_n8_ready", i), int'(ir0), 1);
            if (tbl[i].eov) chk($sformatf("tbl%0d_n8_idx", i), int'(oi0), tbl[i].ei8);
`ifndef DECODER_SCOREBOARD_EN
            chk($sformatf("tbl%0d_n6_valid", i), int'(ov1), int'(tbl[i].eov));
            chk($sformatf("tbl%0d_n6_L", i), int'(l1), tbl[i].el6);
            if (tbl[i].eov) chk($sformatf("tbl%0d_n6_idx", i), int'(oi1), tbl[i].ei6);
`endif
            advance();
        end
        rel_valid = 1'b0;

        // Backpressure: idx 1,2,3 with out_ready low on cycles 2..4.
        do_reset();
        pend = '{1, 2, 3};
        saw_stall = 1'b0;
        for (int c = 0; c < 12; c++) begin
            drive(pend.size() > 0, 1'b1, (pend.size() > 0) ? pend[0] : 0, !(c >= 2 && c <= 4));
            sample_check();
            if (ov0 && out_ready) got.push_back(int'(l0));
            if (!ir0) saw_stall = 1'b1;
            if (in_valid && ir0) void'(pend.pop_front());
            advance();
        end
        chk("bp_count", got.size(), 3);
        chk("bp_stall_seen", int'(saw_stall), 1);
        for (int i = 0; i < 3; i++) begin
            if (i < got.size()) chk($sformatf("bp_order%0d", i), got[i], 2 << i);
        end

        // Reset with main and skid both holding words.
        drive(1'b1, 1'b1, 5, 1'b0);
        sample_check(); advance();
        sample_check(); advance();
        sample_check();
        chk("full_in_ready", int'(ir0), 0);
        reset = 1'b1;
        advance();
        reset = 1'b0;
        in_valid = 1'b0;
        sample_check();
        chk("midrst_out_valid", int'(ov0), 0);
        chk("midrst_L", int'(l0), 0);
        chk("midrst_in_ready", int'(ir0), 0);
        advance();
        sample_check();
        chk("midrst_ready_after", int'(ir0), 1);
        advance();

`ifdef DECODER_SCOREBOARD_EN
        // Hazard stall on a busy target, release, set-wins on the same bit.
        do_reset();
        drive(1'b1, 1'b1, 4, 1'b1); sample_check(); advance();
        in_valid = 1'b0; sample_check(); advance();
        drive(1'b1, 1'b1, 4, 1'b1); sample_check();
        chk("sb_busy_set", int'(busy0), 'h10);
        advance();
        in_valid = 1'b0; sample_check();
        chk("sb_stall0", int'(ov0), 0);
        advance();
        rel_valid = 1'b1; rel_idx = 3'd4; sample_check();
        chk("sb_stall1", int'(ov0), 0);
        advance();
        sample_check();
        chk("sb_released", int'(busy0), 0);
        chk("sb_reissue_valid", int'(ov0), 1);
        advance();
        rel_valid = 1'b0; sample_check();
        chk("sb_set_wins", int'(busy0), 'h10);
        advance();
        // Release of an out-of-range index clamps onto the last target.
        drive(1'b1, 1'b1, 7, 1'b1); sample_check(); advance();
        in_valid = 1'b0; sample_check(); advance();
        sample_check();
        chk("sb_n6_busy", int'(busy1), 'h30);
        rel_valid = 1'b1; rel_idx = 3'd7;
        advance();
        rel_valid = 1'b0; sample_check();
        chk("sb_n6_rel7", int'(busy1), 'h10);
        chk("sb_n8_rel7", int'(busy0), 'h10);
        advance();
`endif

        // Randomised traffic against the model.
        do_reset();
        for (int c = 0; c < 400; c++) begin
            reset     = ($urandom_range(0, 59) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_en     = ($urandom_range(0, 3) != 0);
            read_data = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            rel_valid = ($urandom_range(0, 2) == 0);
            rel_idx   = 3'($urandom_range(0, 7));
            sample_check();
            advance();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
